multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle control unit for the RV32I core. It replaces the single-cycle combinational main decoder with a registered Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. Memory accesses use a ready handshake, so instruction and data memories may stall. It also adds a memory-timeout watchdog and a retired-instruction counter, and it drives every datapath mux select and write enable.

## Interface
- `TIMEOUT`, default 15: maximum consecutive stall cycles in a wait state before `bus_error`; 0 disables the watchdog.
- `PERF_W`, default 32: width of the `instret` counter.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `op` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `zero` in 1: ALU result equals 0.
- `alu_r31` in 1: ALU result bit 31, the compare sign.
- `mem_ready` in 1: memory has completed the current request.
- `pc_write`, `ir_write`, `reg_write` out 1 each: state-element write enables.
- `mem_read`, `mem_write` out 1 each: memory request strobes.
- `adr_src` out 1: memory address select; 0=PC, 1=ALUOut.
- `alu_src_a` out 2: ALU A select; 00=PC, 01=OldPC, 10=rs1, 11=zero.
- `alu_src_b` out 2: ALU B select; 00=rs2, 01=imm, 10=constant 4.
- `result_src` out 2: result select; 00=ALUOut, 01=read data, 10=ALU result.
- `alu_op` out 2: 00=add, 01=subtract/compare, 10=funct decode.
- `imm_src` out 3: I=000, S=001, B=010, J=011, U=100.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `instret` out `PERF_W`: count of retired instructions.
- `bus_error` out 1: one-cycle pulse when the watchdog expires.
- `trap` out 1: illegal-opcode indication.

## Operation
- Outputs are Moore outputs decoded from the registered state.
- Exceptions to the Moore rule:
  - `imm_src` is decoded combinationally from `op` in every state: load/I-ALU/jalr=I, store=S, branch=B, jal=J, lui/auipc=U, any other opcode=000.
  - Strobes in wait states are qualified by `mem_ready`.
- Signals not listed for a state are 0.
- States and their outputs:
  - FETCH: `mem_read`=1, `alu_src_b`=10, `result_src`=10. `ir_write` and `pc_write` equal `mem_ready`. Goes to DECODE when `mem_ready` is 1.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00; this precomputes the branch/jal target.
  - DECODE next-state by `op`:
    - lw/sw go to MEMADR.
    - R-type goes to EXECR.
    - I-ALU goes to EXECI.
    - Branch goes to BRANCH.
    - jal goes to JAL.
    - jalr goes to JALR.
    - `0?10111` (lui/auipc) goes to UPPER.
    - Any other opcode: see Configuration.
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01. Goes to MEMREAD if `op[5]`=0, otherwise to MEMWRITE.
  - MEMREAD: `adr_src`=1, `mem_read`=1. Goes to MEMWB on `mem_ready`.
  - MEMWB: `result_src`=01, `reg_write`=1. Done; goes to FETCH.
  - MEMWRITE: `adr_src`=1, `mem_write`=1. Done on `mem_ready`; goes to FETCH.
  - EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
  - EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Goes to ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1. Done; goes to FETCH.
  - BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=taken. Done; goes to FETCH.
  - Branch taken condition by `funct3`: 000 `zero`; 001 `!zero`; 100/110 `alu_r31`; 101/111 `!alu_r31`; 010/011 never taken.
  - JALR: `alu_src_a`=10, `alu_src_b`=01. Goes to JAL.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_write`=1. Goes to ALUWB, which writes PC+4 to rd.
  - UPPER: `alu_src_a`=01 if `op[5]`=0 (auipc), 11 if `op[5]`=1 (lui). `alu_src_b`=01. Goes to ALUWB.
- Watchdog:
  - A stall counter of width $clog2(TIMEOUT+1) counts cycles spent in FETCH, MEMREAD or MEMWRITE with `mem_ready`=0.
  - The counter clears on any state change.
  - When the counter reaches `TIMEOUT`: `bus_error` pulses, every strobe is forced to 0 that cycle, and the next state is FETCH.
  - If `mem_ready` and timeout expiry occur in the same cycle, `mem_ready` wins.
- `instret` increments on each `instr_done` pulse and wraps modulo 2^`PERF_W`.

## Timing
- Reset:
  - While `reset` is 1, all strobes (`pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`) are 0.
  - On the next edge: state becomes FETCH; `instret`, the stall counter, `bus_error` and `trap` become 0.
  - Reset in any state, including a wait state, aborts the instruction with no write.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles.
  - sw, R-type, I-ALU, jal, lui/auipc: 4 cycles.
  - Branch: 3 cycles.
  - jalr: 5 cycles.
- Each stall cycle extends the relevant state by one cycle.
- `mem_read` and `mem_write` are held stable until the cycle in which `mem_ready` is 1.

## Configuration
- Macro: `MC_CTRL_TRAP_EN`.
- Defined:
  - An undefined opcode in DECODE goes to TRAP.
  - TRAP holds `trap`=1 with all strobes 0 until reset.
  - A watchdog expiry also goes to TRAP instead of FETCH.
- Undefined:
  - An undefined opcode goes DECODE to FETCH, with no `instr_done` and no `instret` increment.
  - `trap` is tied to 0.

## Test plan
- lw with `mem_ready`=1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB -> `reg_write`=1 with `result_src`=01 in cycle 5; `instret` goes 0 to 1.
- beq with `zero`=1, then bne with `zero`=1 -> `pc_write`=1 in BRANCH for beq and 0 for bne; each takes 3 cycles.
- sw with `mem_ready` low for 3 cycles in MEMWRITE -> `mem_write` held 4 cycles; `instr_done` pulses on the 4th.
- `TIMEOUT`=4, FETCH with `mem_ready` stuck at 0 -> `bus_error` pulses at the 5th stall cycle, no `ir_write`, FETCH re-entered.
- With `MC_CTRL_TRAP_EN` defined, `op`=7'b1111111 -> `trap`=1 from the cycle after DECODE until `reset`; without the macro, FETCH follows and `instret` is unchanged.
- `PERF_W`=4, 16 back-to-back R-type instructions -> `instret` wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with ready handshake, stall watchdog and retired-instruction counter.
// Optional trap state for undefined opcodes / watchdog expiry: define MC_CTRL_TRAP_EN.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              zero,
    input  logic              alu_r31,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              adr_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_op,
    output logic [2:0]        imm_src,
    output logic              instr_done,
    output logic [PERF_W-1:0] instret,
    output logic              bus_error,
    output logic              trap
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_UPPER, S_TRAP
    } state_t;

    typedef struct packed {
        logic       adr;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic [1:0] aop;
    } sel_t;

    state_t        state;
    state_t        state_next;
    sel_t          sel_q;
    logic [CW-1:0] stall_cnt;
    logic          in_wait;
    logic          expire;
    logic          taken;

    // Mux selects are registered alongside the state, decoded from the state being entered.
    function automatic sel_t sel_of(input state_t s, input logic op5);
        sel_t r;
        r = '0;
        case (s)
            S_FETCH:    begin r.src_b = 2'b10; r.res = 2'b10; end
            S_DECODE:   begin r.src_a = 2'b01; r.src_b = 2'b01; end
            S_MEMADR:   begin r.src_a = 2'b10; r.src_b = 2'b01; end
            S_MEMREAD:  r.adr = 1'b1;
            S_MEMWB:    r.res = 2'b01;
            S_MEMWRITE: r.adr = 1'b1;
            S_EXECR:    begin r.src_a = 2'b10; r.aop = 2'b10; end
            S_EXECI:    begin r.src_a = 2'b10; r.src_b = 2'b01; r.aop = 2'b10; end
            S_BRANCH:   begin r.src_a = 2'b10; r.aop = 2'b01; end
            S_JALR:     begin r.src_a = 2'b10; r.src_b = 2'b01; end
            S_JAL:      begin r.src_a = 2'b01; r.src_b = 2'b10; end
            S_UPPER:    begin r.src_a = op5 ? 2'b11 : 2'b01; r.src_b = 2'b01; end
            default:    r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        in_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
        expire  = (TIMEOUT != 0) && in_wait && !mem_ready && (stall_cnt == TMAX);
    end

    always_comb begin
        case (funct3)
            3'b000:         taken = zero;
            3'b001:         taken = !zero;
            3'b100, 3'b110: taken = alu_r31;
            3'b101, 3'b111: taken = !alu_r31;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_IALU:           state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI, OP_AUIPC:  state_next = S_UPPER;
`ifdef MC_CTRL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JALR:     state_next = S_JAL;
            S_JAL:      state_next = S_ALUWB;
            S_UPPER:    state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
        if (expire) begin
`ifdef MC_CTRL_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_FETCH;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            sel_q     <= sel_of(S_FETCH, 1'b0);
            stall_cnt <= '0;
            instret   <= '0;
        end else begin
            state <= state_next;
            sel_q <= sel_of(state_next, op[5]);
            // Expiry clears explicitly: FETCH -> FETCH is not a state change.
            if (expire || (state_next != state)) begin
                stall_cnt <= '0;
            end else if ((TIMEOUT != 0) && in_wait && !mem_ready) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if (instr_done) begin
                instret <= instret + PERF_W'(1);
            end
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read = !expire;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_MEMREAD:  mem_read = !expire;
                S_MEMWB:    begin reg_write = 1'b1; instr_done = 1'b1; end
                S_MEMWRITE: begin mem_write = !expire; instr_done = mem_ready; end
                S_ALUWB:    begin reg_write = 1'b1; instr_done = 1'b1; end
                S_BRANCH:   begin pc_write = taken; instr_done = 1'b1; end
                S_JAL:      pc_write = 1'b1;
                default:    ;
            endcase
        end
    end

    assign bus_error  = expire && !reset;
    assign adr_src    = sel_q.adr;
    assign alu_src_a  = sel_q.src_a;
    assign alu_src_b  = sel_q.src_b;
    assign result_src = sel_q.res;
    assign alu_op     = sel_q.aop;

`ifdef MC_CTRL_TRAP_EN
    assign trap = (state == S_TRAP);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        case (op)
            OP_LOAD, OP_IALU, OP_JALR: imm_src = 3'b000;
            OP_STORE:                  imm_src = 3'b001;
            OP_BRANCH:                 imm_src = 3'b010;
            OP_JAL:                    imm_src = 3'b011;
            OP_LUI, OP_AUIPC:          imm_src = 3'b100;
            default:                   imm_src = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: per-instruction expected cycle sequences built from the opcode class.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned PW = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    op;
    logic [2:0]    funct3;
    logic          zero;
    logic          alu_r31;
    logic          mem_ready;
    logic          pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
    logic [1:0]    alu_src_a, alu_src_b, result_src, alu_op;
    logic [2:0]    imm_src;
    logic          instr_done;
    logic [PW-1:0] instret;
    logic          bus_error;
    logic          trap;

    int checks   = 0;
    int failures = 0;
    int exp_ret  = 0;
    logic exp_trap = 1'b0;

    multicycle_ctrl #(.TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .alu_r31(alu_r31),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op), .imm_src(imm_src),
        .instr_done(instr_done), .instret(instret), .bus_error(bus_error), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, src_a, src_b, result_src, alu_op, done, bus_error}
    function automatic logic [15:0] mk(input logic pcw, input logic irw, input logic rw, input logic mr,
                                       input logic mw, input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] r, input logic [1:0] o,
                                       input logic d, input logic e);
        return {pcw, irw, rw, mr, mw, adr, a, b, r, o, d, e};
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        if (o == LW || o == IA || o == JR) return 3'b000;
        if (o == SW) return 3'b001;
        if (o == BR) return 3'b010;
        if (o == JL) return 3'b011;
        if (o == LUI || o == AUI) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic br_taken(input logic [2:0] f, input logic z, input logic n);
        case (f)
            3'b000: return z;
            3'b001: return !z;
            3'b100, 3'b110: return n;
            3'b101, 3'b111: return !n;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at a negedge: drive mem_ready, check this cycle, advance to next negedge.
    task automatic step(input logic mr, input logic [15:0] exp, input string tag);
        mem_ready = mr;
        #1;
        check_val(tag, {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, alu_src_a,
                        alu_src_b, result_src, alu_op, instr_done, bus_error}, 32'(exp));
        check_val("imm_src", 32'(imm_src), 32'(exp_imm(op)));
        check_val("instret", 32'(instret), 32'(exp_ret));
        check_val("trap", 32'(trap), 32'(exp_trap));
        if (exp[1]) exp_ret = (exp_ret + 1) % (1 << PW);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = rnd();
        #1;
        check_val("reset_strobes", {27'd0, pc_write, ir_write, reg_write, mem_read, mem_write}, 32'd0);
        check_val("reset_done", 32'(instr_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 0;
        exp_trap = 1'b0;
    endtask

    task automatic after_timeout();
`ifdef MC_CTRL_TRAP_EN
        exp_trap = 1'b1;
        step(rnd(), 16'd0, "trap_hold");
        step(rnd(), 16'd0, "trap_hold");
        do_reset();
`endif
    endtask

    // Returns 1 when the fetch completed, 0 when it timed out.
    task automatic do_fetch(input int stalls, input bit tmo, output bit ok);
        int n;
        n = tmo ? int'(TO) : stalls;
        for (int i = 0; i < n; i++) step(1'b0, mk(0,0,0,1,0,0,2'b00,2'b10,2'b10,2'b00,0,0), "fetch_stall");
        if (tmo) begin
            step(1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,1), "fetch_timeout");
            after_timeout();
            ok = 1'b0;
        end else begin
            step(1'b1, mk(1,1,0,1,0,0,2'b00,2'b10,2'b10,2'b00,0,0), "fetch");
            ok = 1'b1;
        end
    endtask

    task automatic aluwb();
        step(rnd(), mk(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0), "aluwb");
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z, input logic n,
                             input int fst, input int mst, input bit mto);
        bit ok;
        int ns;
        op = o; funct3 = f3; zero = z; alu_r31 = n;
        do_fetch(fst, 1'b0, ok);
        step(rnd(), mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0), "decode");
        ns = mto ? int'(TO) : mst;
        case (o)
            LW, SW: begin
                step(rnd(), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0), "memadr");
                for (int i = 0; i < ns; i++)
                    step(1'b0, mk(0,0,0,o==LW,o==SW,1,2'b00,2'b00,2'b00,2'b00,0,0), "mem_stall");
                if (mto) begin
                    step(1'b0, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,1), "mem_timeout");
                    after_timeout();
                end else if (o == LW) begin
                    step(1'b1, mk(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0,0), "memread");
                    step(rnd(), mk(0,0,1,0,0,0,2'b00,2'b00,2'b01,2'b00,1,0), "memwb");
                end else begin
                    step(1'b1, mk(0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,1,0), "memwrite");
                end
            end
            RT: begin step(rnd(), mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,0,0), "execr"); aluwb(); end
            IA: begin step(rnd(), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,0,0), "execi"); aluwb(); end
            BR: step(rnd(), mk(br_taken(f3, z, n),0,0,0,0,0,2'b10,2'b00,2'b00,2'b01,1,0), "branch");
            JL: begin step(rnd(), mk(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0,0), "jal"); aluwb(); end
            JR: begin
                step(rnd(), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0), "jalr");
                step(rnd(), mk(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0,0), "jal");
                aluwb();
            end
            LUI, AUI: begin
                step(rnd(), mk(0,0,0,0,0,0,(o == LUI) ? 2'b11 : 2'b01,2'b01,2'b00,2'b00,0,0), "upper");
                aluwb();
            end
            default: begin
`ifdef MC_CTRL_TRAP_EN
                exp_trap = 1'b1;
                for (int i = 0; i < 3; i++) step(rnd(), 16'd0, "trap_hold");
                do_reset();
`endif
            end
        endcase
    endtask

    initial begin
        logic [6:0] ops [12];
        bit ok;
        ops = '{LW, SW, RT, IA, BR, JL, JR, LUI, AUI, 7'b1111111, 7'b0000000, 7'b0001111};
        op = LW; funct3 = '0; zero = 1'b0; alu_r31 = 1'b0; mem_ready = 1'b1;
        do_reset();

        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
        check_val("lw_retired", 32'(instret), 32'd1);
        run_instr(BR, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(BR, 3'b001, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 4, 0, 1'b0);
        do_fetch(0, 1'b1, ok);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 2, 0, 1'b1);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);

        // Reset during a memory stall aborts with no write.
        op = LW;
        do_fetch(0, 1'b0, ok);
        step(rnd(), mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0), "decode");
        step(rnd(), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0), "memadr");
        step(1'b0, mk(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0,0), "mem_stall");
        do_reset();

        for (int i = 0; i < 16; i++) run_instr(RT, 3'($urandom), rnd(), rnd(), 0, 0, 1'b0);
        #1;
        check_val("instret_wrap", 32'(instret), 32'd0);

        for (int i = 0; i < 80; i++) begin
            logic [6:0] o;
            o = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) do_fetch(0, 1'b1, ok);
            run_instr(o, 3'($urandom), rnd(), rnd(), $urandom_range(0, TO), $urandom_range(0, TO),
                      ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
